// File: rtl/user_counter_wbs.sv
// Wishbone classic responder exposing a limit-wrapping counter with
// control/status registers, GPIO mirror of the count and a match IRQ.
module user_counter_wbs #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned ACK_DELAY = 1,
    parameter int unsigned IO_W      = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic [IO_W-1:0] io_out,
    output logic [IO_W-1:0] io_oeb,
    output logic            irq
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    localparam logic [2:0] DLY_INIT = 3'(ACK_DELAY - 1);

    state_t      state, state_nx;
    logic [2:0]  dly, dly_nx;
    logic        we_q, hit_q;
    logic [1:0]  off_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;
    logic        en, irq_en, match, irq_q;
    logic [31:0] count, limit, rdata;
    logic        wr_hit, wrap, clr;
    logic        unused_ok;

    assign unused_ok = &{1'b0, wbs_adr_i[1:0]};

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] nv,
        input logic [3:0]  s
    );
        merge = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) merge[8*b +: 8] = nv[8*b +: 8];
    endfunction

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            dly   <= '0;
        end else begin
            state <= state_nx;
            dly   <= dly_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dly_nx   = dly;
        unique case (state)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    state_nx = WAIT;
                    dly_nx   = DLY_INIT;
                end
            end
            WAIT: begin
                if (!wbs_cyc_i)
                    state_nx = IDLE;
                else if (dly == 3'd0)
                    state_nx = ACK;
                else
                    dly_nx = dly - 3'd1;
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o = (state == ACK);
        wr_hit    = wbs_ack_o && we_q && hit_q;
        wbs_dat_o = wbs_ack_o ? rdata : 32'd0;
    end

    // Request is captured once at accept; the bus may change it afterwards.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            we_q  <= 1'b0;
            hit_q <= 1'b0;
            off_q <= '0;
            sel_q <= '0;
            dat_q <= '0;
        end else if (state == IDLE && wbs_cyc_i && wbs_stb_i) begin
            we_q  <= wbs_we_i;
            hit_q <= (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
            off_q <= wbs_adr_i[3:2];
            sel_q <= wbs_sel_i;
            dat_q <= wbs_dat_i;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (hit_q) begin
            unique case (off_q)
                2'd0: rdata = {30'd0, irq_en, en};
                2'd1: rdata = count;
                2'd2: rdata = limit;
                2'd3: rdata = {31'd0, match};
                default: rdata = 32'd0;
            endcase
        end
    end

    assign wrap = en && (count == limit);
    assign clr  = wr_hit && (off_q == 2'd3) && sel_q[0] && dat_q[0];

    // Bus writes to COUNT override the counter; a new match beats a clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en     <= 1'b0;
            irq_en <= 1'b0;
            count  <= '0;
            limit  <= '1;
            match  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wrap)
                count <= '0;
            else if (en)
                count <= count + 32'd1;
            if (wr_hit && off_q == 2'd1)
                count <= merge(count, dat_q, sel_q);
            if (wr_hit && off_q == 2'd2)
                limit <= merge(limit, dat_q, sel_q);
            if (wr_hit && off_q == 2'd0 && sel_q[0]) begin
                en     <= dat_q[0];
                irq_en <= dat_q[1];
            end
            match <= wrap | (match & ~clr);
            irq_q <= match & irq_en;
        end
    end

    assign io_out = count[IO_W-1:0];
    assign io_oeb = '0;
    assign irq    = irq_q;

endmodule

// File: tb/tb_user_counter_wbs.sv
// Randomised bench for user_counter_wbs against a rule-level register model,
// plus a slow-ack instance for abort, latency and reset checks.
module tb_user_counter_wbs;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, cyc4, stb4, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack, ack4, irq, irq4;
    logic [31:0] dout, dout4;
    logic [15:0] io, io4, oeb, oeb4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    user_counter_wbs dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack), .wbs_dat_o(dout),
        .io_out(io), .io_oeb(oeb), .irq(irq)
    );

    user_counter_wbs #(.ACK_DELAY(4)) dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc4), .wbs_stb_i(stb4), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack4), .wbs_dat_o(dout4),
        .io_out(io4), .io_oeb(oeb4), .irq(irq4)
    );

    // Reference model of the register file
    logic        m_en, m_ie, m_match, m_irq;
    logic [31:0] m_count, m_limit;
    logic        pw = 1'b0;
    logic [1:0]  pw_off;
    logic [3:0]  pw_sel;
    logic [31:0] pw_dat;

    function automatic logic [31:0] lanes(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    function automatic logic is_hit(input logic [31:0] a);
        return (a >> 4) == (BASE >> 4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!is_hit(a)) return 32'd0;
        case (a[3:2])
            2'd0:    return {30'd0, m_ie, m_en};
            2'd1:    return m_count;
            2'd2:    return m_limit;
            default: return {31'd0, m_match};
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_en <= 0; m_ie <= 0; m_match <= 0; m_irq <= 0;
            m_count <= 0; m_limit <= 32'hFFFF_FFFF;
        end else begin
            m_irq <= m_match && m_ie;
            if (pw && pw_off == 2'd0 && pw_sel[0]) begin
                m_en <= pw_dat[0];
                m_ie <= pw_dat[1];
            end
            if (pw && pw_off == 2'd1)
                m_count <= lanes(m_count, pw_dat, pw_sel);
            else if (m_en)
                m_count <= (m_count == m_limit) ? 32'd0 : m_count + 1;
            if (pw && pw_off == 2'd2)
                m_limit <= lanes(m_limit, pw_dat, pw_sel);
            if (m_en && m_count == m_limit)
                m_match <= 1'b1;
            else if (pw && pw_off == 2'd3 && pw_sel[0] && pw_dat[0])
                m_match <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            check("io", {16'd0, io}, {16'd0, m_count[15:0]});
            check("irq", {31'd0, irq}, {31'd0, m_irq});
        end
    endtask

    // One bus transfer started at a negedge, ending at the negedge after ack.
    task automatic xfer(input bit on4, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd);
        int lat;
        logic [31:0] exp;
        we = w; adr = a; sel = s; dat = d;
        if (on4) begin cyc4 = 1; stb4 = 1; end
        else begin cyc = 1; stb = 1; end
        lat = 0;
        rd = 0;
        exp = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge clk);
            if (on4 ? ack4 : ack) lat = i;
            else check("dat_idle", on4 ? dout4 : dout, 32'd0);
        end
        check("ack_lat", lat, on4 ? 32'd5 : 32'd2);
        rd = on4 ? dout4 : dout;
        if (!on4) begin
            exp = model_read(a);
            if (!w) check("rdata", rd, exp);
            if (w && is_hit(a)) begin
                pw_off = a[3:2]; pw_sel = s; pw_dat = d; pw = 1'b1;
            end
        end
        cyc = 0; stb = 0; cyc4 = 0; stb4 = 0;
        @(negedge clk);
        pw = 1'b0;
        check("ack_1cyc", {31'd0, on4 ? ack4 : ack}, 32'd0);
        check("dat_zero", on4 ? dout4 : dout, 32'd0);
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        logic [31:0] r;
        xfer(0, 1, BASE | {28'd0, off, 2'b00}, 4'hF, d, r);
    endtask

    task automatic rdr(input logic [1:0] off, output logic [31:0] r);
        xfer(0, 0, BASE | {28'd0, off, 2'b00}, 4'hF, 32'd0, r);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a, d;
        logic [1:0]  off;
        rst = 1; cyc = 0; stb = 0; cyc4 = 0; stb4 = 0;
        we = 0; sel = 0; adr = 0; dat = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dout, 32'd0);
        check("rst_io", {16'd0, io}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("oeb", {16'd0, oeb}, 32'd0);
        rdr(2'd0, r); check("rst_ctrl", r, 32'd0);
        rdr(2'd1, r); check("rst_count", r, 32'd0);
        rdr(2'd2, r); check("rst_limit", r, 32'hFFFF_FFFF);
        rdr(2'd3, r); check("rst_status", r, 32'd0);

        wr(2'd2, 32'd5); wr(2'd1, 32'd0); wr(2'd0, 32'd1);
        for (int i = 0; i < 12; i++) begin
            check("seq", {16'd0, io}, i % 6);
            @(negedge clk);
        end
        rdr(2'd3, r); check("match_set", r, 32'd1);

        wr(2'd0, 32'd0); wr(2'd1, 32'd0); wr(2'd2, 32'd3);
        wr(2'd3, 32'd1); wr(2'd0, 32'd3);
        run(12);
        wr(2'd3, 32'd1);
        run(10);

        wr(2'd0, 32'd0); wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd1, 32'h1234_0000);
        xfer(0, 1, BASE | 32'h4, 4'b0011, 32'h0000_AB60, r);
        rdr(2'd1, r); check("byte_wr", r, 32'h1234_AB60);
        wr(2'd0, 32'd1);
        check("io_hold", {16'd0, io}, 32'h0000_AB60);
        @(negedge clk);
        check("io_next", {16'd0, io}, 32'h0000_AB61);

        xfer(0, 1, BASE | 32'h10, 4'hF, 32'd9, r);
        xfer(0, 0, BASE | 32'h10, 4'hF, 32'd0, r);
        check("miss_rd", r, 32'd0);
        rdr(2'd2, r); check("miss_nowr", r, 32'hFFFF_FFFF);

        we = 1; adr = BASE | 32'h8; sel = 4'hF; dat = 32'd7;
        cyc = 1; stb = 1;
        @(negedge clk);
        cyc = 0; stb = 0;
        repeat (4) begin
            @(negedge clk);
            check("abort_ack", {31'd0, ack}, 32'd0);
        end
        rdr(2'd2, r); check("abort_lim", r, 32'hFFFF_FFFF);

        // Clear lands on the same edge as a wrap.
        wr(2'd0, 32'd0); wr(2'd1, 32'd0); wr(2'd2, 32'd8);
        wr(2'd3, 32'd1); wr(2'd0, 32'd3);
        for (int i = 0; i < 40 && m_count != 32'd6; i++) run(1);
        check("sync", {16'd0, io}, 32'd6);
        wr(2'd3, 32'd1);
        rdr(2'd3, r); check("w1c_vs_wrap", r, 32'd1);
        wr(2'd1, 32'h0000_0100);
        check("cnt_wr_wins", {16'd0, io}, 32'h0000_0100);
        run(3);

        for (int it = 0; it < 120; it++) begin
            off = 2'($urandom_range(0, 3));
            a = BASE | {28'd0, off, 2'b00};
            if ($urandom_range(0, 7) == 0) a = a + 32'h10 * $urandom_range(1, 4);
            case (off)
                2'd1: d = $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom;
                2'd2: d = $urandom_range(0, 30);
                default: d = $urandom;
            endcase
            xfer(0, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), d, r);
            run($urandom_range(0, 5));
        end

        xfer(1, 0, BASE | 32'h8, 4'hF, 32'd0, r);
        check("d4_lim", r, 32'hFFFF_FFFF);
        we = 1; adr = BASE | 32'h8; sel = 4'hF; dat = 32'd7;
        cyc4 = 1; stb4 = 1;
        repeat (2) @(negedge clk);
        cyc4 = 0; stb4 = 0;
        repeat (8) begin
            @(negedge clk);
            check("d4_abort", {31'd0, ack4}, 32'd0);
        end
        xfer(1, 0, BASE | 32'h8, 4'hF, 32'd0, r);
        check("d4_abort_lim", r, 32'hFFFF_FFFF);

        wr(2'd2, 32'h100); wr(2'd1, 32'h55); wr(2'd0, 32'd3);
        we = 0; adr = BASE | 32'h4; sel = 4'hF;
        cyc = 1; stb = 1; cyc4 = 1; stb4 = 1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_ack", {31'd0, ack}, 32'd1);
        rst = 1;
        #1;
        check("rst_ack_drop", {31'd0, ack}, 32'd0);
        check("rst_dat_drop", dout, 32'd0);
        check("rst_ack4", {31'd0, ack4}, 32'd0);
        @(negedge clk);
        rst = 0; cyc = 0; stb = 0; cyc4 = 0; stb4 = 0;
        repeat (8) begin
            @(negedge clk);
            check("post_rst_ack", {30'd0, ack, ack4}, 32'd0);
        end
        rdr(2'd0, r); check("rst2_ctrl", r, 32'd0);
        rdr(2'd1, r); check("rst2_count", r, 32'd0);
        rdr(2'd2, r); check("rst2_limit", r, 32'hFFFF_FFFF);
        rdr(2'd3, r); check("rst2_status", r, 32'd0);
        check("d4_quiet", {io4, oeb4}, 32'd0);
        check("d4_irq", {31'd0, irq4}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
